// File: rtl/rob_dispatch_ctrl.sv
// Dispatch-width arbiter plus mispredict/halt sequencer in front of the ROB.
// Grants min(supply, free ROB/RS/FL slots) and sequences squash/recover/halt.
module rob_dispatch_ctrl #(
    parameter int N              = 3,
    parameter int DEPTH          = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int LOG_DEPTH      = $clog2(DEPTH),
    parameter int AW             = $clog2(N + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AW-1:0]        inst_avail,
    input  logic [AW-1:0]        rob_open,
    input  logic [AW-1:0]        rs_open,
    input  logic [AW-1:0]        fl_open,
    input  logic                 mispredict,
    input  logic [LOG_DEPTH-1:0] mispred_tail,
    input  logic                 retire_halt,
    output logic [AW-1:0]        num_accept,
    output logic                 br_en,
    output logic [LOG_DEPTH-1:0] br_tail,
    output logic                 squashing,
    output logic                 halted,
    output logic [15:0]          stall_cnt
);

    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SQUASH  = 2'd1,
        RECOVER = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t               state_q;
    logic [LOG_DEPTH-1:0] br_tail_q;
    logic [CW-1:0]        recover_cnt_q;
    logic [15:0]          stall_cnt_q;

    logic [AW-1:0] min_open;
    logic          dispatch_ok;
    logic          stall_evt;

    always_comb begin
        min_open = inst_avail;
        if (rob_open < min_open) min_open = rob_open;
        if (rs_open < min_open)  min_open = rs_open;
        if (fl_open < min_open)  min_open = fl_open;
    end

    // Mispredict and halt cycles dispatch nothing (zero-cycle squash).
    assign dispatch_ok = !reset && (state_q == NORMAL)
                         && !mispredict && !retire_halt;
    assign num_accept  = dispatch_ok ? min_open : '0;
    assign stall_evt   = dispatch_ok && (inst_avail != '0)
                         && (min_open < inst_avail);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= NORMAL;
            br_tail_q     <= '0;
            recover_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;

            case (state_q)
                NORMAL: begin
                    if (retire_halt) begin
                        state_q <= HALTED;
                    end else if (mispredict) begin
                        state_q   <= SQUASH;
                        br_tail_q <= mispred_tail;
                    end
                end
                SQUASH, RECOVER: begin
                    if (retire_halt) begin
                        state_q <= HALTED;
                    end else if (mispredict) begin
                        state_q   <= SQUASH;
                        br_tail_q <= mispred_tail;
                    end else if (state_q == SQUASH) begin
                        state_q       <= RECOVER;
                        recover_cnt_q <= CW'(RECOVER_CYCLES - 1);
                    end else if (recover_cnt_q == '0) begin
                        state_q <= NORMAL;
                    end else begin
                        recover_cnt_q <= recover_cnt_q - 1'b1;
                    end
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    assign br_en     = (state_q == SQUASH);
    assign br_tail   = br_en ? br_tail_q : '0;
    assign squashing = (state_q == SQUASH) || (state_q == RECOVER);
    assign halted    = (state_q == HALTED);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Directed bench for rob_dispatch_ctrl (N=3, DEPTH=32, RECOVER_CYCLES=2).
module tb_rob_dispatch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  inst_avail, rob_open, rs_open, fl_open;
    logic        mispredict;
    logic [4:0]  mispred_tail;
    logic        retire_halt;
    logic [1:0]  num_accept;
    logic        br_en;
    logic [4:0]  br_tail;
    logic        squashing;
    logic        halted;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    rob_dispatch_ctrl #(.N(3), .DEPTH(32), .RECOVER_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .inst_avail(inst_avail), .rob_open(rob_open),
        .rs_open(rs_open), .fl_open(fl_open),
        .mispredict(mispredict), .mispred_tail(mispred_tail),
        .retire_halt(retire_halt),
        .num_accept(num_accept), .br_en(br_en), .br_tail(br_tail),
        .squashing(squashing), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int av, input int ro, input int rs,
                         input int fl, input bit mp, input int tl,
                         input bit hl);
        inst_avail   = 2'(av);
        rob_open     = 2'(ro);
        rs_open      = 2'(rs);
        fl_open      = 2'(fl);
        mispredict   = mp;
        mispred_tail = 5'(tl);
        retire_halt  = hl;
    endtask

    task automatic expect_out(input string tag, input int na, input bit be,
                              input int bt, input bit sq, input bit hl);
        @(negedge clock);
        chk({tag, ".num_accept"}, 32'(num_accept), 32'(na));
        chk({tag, ".br_en"}, 32'(br_en), 32'(be));
        chk({tag, ".br_tail"}, 32'(br_tail), 32'(bt));
        chk({tag, ".squashing"}, 32'(squashing), 32'(sq));
        chk({tag, ".halted"}, 32'(halted), 32'(hl));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(3, 3, 3, 3, 0, 0, 0);
        expect_out("rst0", 0, 0, 0, 0, 0);
        tick;
        expect_out("rst1", 0, 0, 0, 0, 0);
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        tick;
        reset = 1'b0;

        // T1: ROB/FL limit grant to 1, stall counted every cycle
        drive(3, 2, 3, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_out("t1", 1, 0, 0, 0, 0);
            chk("t1.stall_cnt", 32'(stall_cnt), 32'(i));
            tick;
        end
        drive(2, 3, 3, 3, 0, 0, 0);
        expect_out("full", 2, 0, 0, 0, 0);
        tick;
        drive(0, 3, 3, 3, 0, 0, 0);
        expect_out("idle", 0, 0, 0, 0, 0);
        tick;
        drive(3, 3, 1, 3, 0, 0, 0);
        expect_out("rs_lim", 1, 0, 0, 0, 0);
        tick;
        chk("t1.stall_end", 32'(stall_cnt), 5);

        // T2: single mispredict, tail 5
        drive(3, 3, 3, 3, 1, 5, 0);
        expect_out("t2.T", 0, 0, 0, 0, 0);
        tick;
        drive(3, 3, 3, 3, 0, 0, 0);
        expect_out("t2.T1", 0, 1, 5, 1, 0);
        tick;
        expect_out("t2.T2", 0, 0, 0, 1, 0);
        tick;
        expect_out("t2.T3", 0, 0, 0, 1, 0);
        tick;
        expect_out("t2.T4", 3, 0, 0, 0, 0);
        chk("t2.stall_cnt", 32'(stall_cnt), 5);
        tick;

        // T3: second mispredict during RECOVER restarts the window
        drive(3, 3, 3, 3, 1, 7, 0);
        expect_out("t3.T", 0, 0, 0, 0, 0);
        tick;
        drive(3, 3, 3, 3, 0, 0, 0);
        expect_out("t3.T1", 0, 1, 7, 1, 0);
        tick;
        drive(3, 3, 3, 3, 1, 3, 0);
        expect_out("t3.T2", 0, 0, 0, 1, 0);
        tick;
        drive(3, 3, 3, 3, 0, 0, 0);
        expect_out("t3.T3", 0, 1, 3, 1, 0);
        tick;
        expect_out("t3.T4", 0, 0, 0, 1, 0);
        tick;
        expect_out("t3.T5", 0, 0, 0, 1, 0);
        tick;
        expect_out("t3.T6", 3, 0, 0, 0, 0);
        tick;

        // T5: reset pulse during RECOVER
        drive(3, 3, 3, 3, 1, 2, 0);
        expect_out("t5.T", 0, 0, 0, 0, 0);
        tick;
        drive(3, 3, 3, 3, 0, 0, 0);
        expect_out("t5.T1", 0, 1, 2, 1, 0);
        tick;
        reset = 1'b1;
        expect_out("t5.rst", 0, 0, 0, 1, 0);
        tick;
        reset = 1'b0;
        expect_out("t5.after", 3, 0, 0, 0, 0);
        chk("t5.stall_cnt", 32'(stall_cnt), 0);
        tick;

        // T4: halt beats mispredict, then absorbing
        drive(3, 3, 3, 3, 1, 9, 1);
        expect_out("t4.T", 0, 0, 0, 0, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(3, 3, 3, 3, i[0], 4, 0);
            expect_out("t4.halt", 0, 0, 0, 0, 1);
            tick;
        end
        chk("t4.stall_cnt", 32'(stall_cnt), 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;

        // T6: max tail passthrough, then saturating stall counter
        drive(3, 3, 3, 3, 1, 31, 0);
        expect_out("t6.T", 0, 0, 0, 0, 0);
        tick;
        drive(1, 0, 3, 3, 0, 0, 0);
        expect_out("t6.T1", 0, 1, 31, 1, 0);
        tick;
        tick;
        tick;
        expect_out("t6.stall", 0, 0, 0, 0, 0);
        chk("t6.stall_start", 32'(stall_cnt), 0);
        repeat (65540) tick;
        @(negedge clock);
        chk("t6.stall_sat", 32'(stall_cnt), 32'hFFFF);
        tick;
        drive(2, 3, 3, 3, 0, 0, 0);
        expect_out("t6.resume", 2, 0, 0, 0, 0);
        chk("t6.stall_hold", 32'(stall_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
